btn_debounce: RTL
=================

// Module: btn_debounce
// PURPOSE
//  Input conditioner between raw board pins (push buttons, slide switches) and the
//  SoC. Synchronises, debounces and edge-detects `width` asynchronous inputs.
//  Raises a maskable sticky interrupt on debounced edges.
//  Its outputs feed wb_gpio gpio_in and intr_n directly, replacing the raw btn wiring.
// PARAMETERS
//  clk_freq        50000000  system clock frequency in Hz
//  sample_us       1000      sample tick period in us; tick_div = clk_freq/1000000*sample_us (>=1)
//  stable_samples  8         consecutive differing samples needed to flip an output (>=1)
//  width           4         number of conditioned inputs
// PORTS
//  clk       in   1      system clock
//  reset     in   1      asynchronous, active-high reset
//  raw_in    in   width  raw asynchronous pin levels
//  irq_mask  in   width  1 = edges on this input set pending
//  pend_clr  in   width  1-cycle pulses, clear pending bits
//  deb_out   out  width  debounced level
//  rise      out  width  1-cycle pulse on debounced 0->1
//  fall      out  width  1-cycle pulse on debounced 1->0
//  pend      out  width  sticky pending edge flags
//  intr      out  1      |pend, registered
// BEHAVIOUR
//  - Reset: all flops clear; deb_out/rise/fall/pend/intr = 0; prescaler = 0; per-input counters = 0.
//  - Sync: 2-FF synchroniser per input, reset value 0. sync = second stage.
//  - Prescaler:
//    - Counts 0..tick_div-1 and wraps.
//    - tick is high for one cycle when count == tick_div-1.
//    - tick_div == 1 -> tick high every cycle.
//  - Per input i, counter width $clog2(stable_samples+1):
//    - sync == deb_out[i] -> counter <= 0, whether or not tick is high. This makes any glitch restart the count.
//    - tick && sync != deb_out[i] && counter == stable_samples-1 -> deb_out[i] toggles, counter <= 0.
//    - Same condition with counter below stable_samples-1 -> counter increments.
//    - No tick -> counter holds.
//  - Edges: rise/fall are registered. Each is high in the same cycle deb_out shows its new value, for exactly one cycle.
//    - Never both high on one input.
//  - Latency, raw_in change to deb_out change, with the input held stable:
//    - 2 sync cycles + stable_samples ticks.
//    - With tick_div=1 this is exactly 2+stable_samples cycles.
//  - Pending:
//    - pend[i] sets on (rise[i]|fall[i]) & irq_mask[i], seen one cycle after the pulse.
//    - pend[i] clears on pend_clr[i].
//    - Set and clear in the same cycle -> set wins, pend stays 1.
//    - irq_mask = 0 does not clear existing pend bits.
//  - intr = |pend, registered one cycle after pend.
//  - Reset mid-count: counters abort; no rise/fall pulse on deassert.
//    deb_out restarts at 0, so a held-high input re-qualifies and then produces a rise.
//  - Inputs are independent. Simultaneous edges on several inputs each pulse and set their own pend bit.
// STRUCTURE
//  - No shared package needed; tick_div and counter width are localparams in this file.
//  - One sub-module, debounce_cell, holds: synchroniser, counter, deb/rise/fall for one bit.
//    It is instantiated `width` times via generate.
//  - Prescaler and pending/intr logic live in btn_debounce.
// TESTING (bench: clk_freq=1000000, sample_us=1 -> tick_div=1, stable_samples=4, width=4)
//  1. Reset asserted 3 cycles, raw_in=4'hF
//     -> deb_out/rise/fall/pend/intr all 0 during reset.
//     -> deb_out=4'hF 6 cycles after release, with rise=4'hF pulsing once.
//  2. raw_in[0] 0->1 held, irq_mask=4'h1
//     -> deb_out[0]=1 and rise[0]=1 at the 6th edge after the change.
//     -> pend[0]=1 at the 7th edge, intr=1 at the 8th edge.
//  3. raw_in[1] high for 3 cycles then low (glitch) -> deb_out[1], rise[1], pend[1] stay 0.
//  4. irq_mask=0, raw_in[2] 0->1->0, each level held 10 cycles
//     -> rise[2] and fall[2] each pulse once; pend stays 0, intr stays 0.
//  5. pend[0]=1, then pend_clr[0]=1 in the same cycle as a new masked edge on input 0
//     -> pend[0] stays 1.
//     -> A later lone pend_clr[0] gives pend[0]=0, and intr=0 one cycle later.
//  6. raw_in[3] high for 3 cycles, then reset pulsed while raw_in[3] is still high
//     -> deb_out[3]=0 with no pulse during reset.
//     -> deb_out[3]=1 with rise[3] exactly 6 cycles after reset release.

Source files
------------

// File: rtl/debounce_cell.sv
// One conditioned input: 2-FF synchroniser, stability counter, debounced level
// and registered single-cycle edge pulses aligned with the level change.
module debounce_cell #(
  parameter int stable_samples = 8,
  parameter int cnt_w          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic deb,
  output logic rise,
  output logic fall
);

  logic             sync_1;
  logic             sync_2;
  logic [cnt_w-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      deb    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Any sample agreeing with the current level restarts qualification, tick or not.
      if (sync_2 == deb) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == cnt_w'(stable_samples - 1)) begin
          deb  <= ~deb;
          cnt  <= '0;
          rise <= ~deb;
          fall <= deb;
        end else begin
          cnt <= cnt + cnt_w'(1);
        end
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Input conditioner for board buttons/switches: shared sample prescaler,
// per-input debounce cells, sticky maskable pending flags and a registered interrupt.
module btn_debounce #(
  parameter int clk_freq       = 50000000,
  parameter int sample_us      = 1000,
  parameter int stable_samples = 8,
  parameter int width          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] raw_in,
  input  logic [width-1:0] irq_mask,
  input  logic [width-1:0] pend_clr,
  output logic [width-1:0] deb_out,
  output logic [width-1:0] rise,
  output logic [width-1:0] fall,
  output logic [width-1:0] pend,
  output logic             intr
);

  localparam int tick_div = clk_freq / 1000000 * sample_us;
  localparam int pre_w    = (tick_div > 1) ? $clog2(tick_div) : 1;
  localparam int cnt_w    = $clog2(stable_samples + 1);

  logic [pre_w-1:0] pre_cnt;
  logic             tick;

  // With tick_div == 1 the count never leaves 0, so tick stays high every cycle.
  assign tick = (pre_cnt == pre_w'(tick_div - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + pre_w'(1);
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_cell
    debounce_cell #(
      .stable_samples (stable_samples),
      .cnt_w          (cnt_w)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .tick  (tick),
      .deb   (deb_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // A new masked edge wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      intr <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | ((rise | fall) & irq_mask);
      intr <= |pend;
    end
  end

endmodule
